// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared types and constants for the PmodJSTK reader
// Purpose: frame-sequencer state enum, joystick command/frame constants,
//          bit offsets of each received byte slot inside the 40-bit frame,
//          and a small helper for sizing counters.
// Ports:   none (package).
package jstk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_GAP,
    ST_FINISH,
    ST_WAIT
  } jstk_state_t;

  localparam logic [7:0] JSTK_CMD    = 8'h80;
  localparam int         JSTK_NBYTES = 5;

  // Received byte k lands at the slot below; byte 0 is the most significant.
  localparam int JSTK_OFS_X_LO = 32;
  localparam int JSTK_OFS_X_HI = 24;
  localparam int JSTK_OFS_Y_LO = 16;
  localparam int JSTK_OFS_Y_HI = 8;
  localparam int JSTK_OFS_BTN  = 0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_byte_xfer.sv
// rtl/spi_byte_xfer.sv - single SPI mode-0 byte exchange engine
// Purpose: on a start pulse, shifts tx_byte out MSB first while shifting
//          miso into rx_byte. sclk rises on the same edge that accepts start,
//          so the first data bit is already on mosi (it tracks tx_byte[7]
//          while idle). mosi changes on sclk falling, miso is sampled on sclk
//          rising. A byte lasts 16*CLK_DIV clocks and ends with sclk low.
// Ports:   clk, reset (async, active-high)
//          start    - begin a byte exchange (ignored while running)
//          tx_byte  - byte to transmit, must be stable while idle
//          miso     - serial data in
//          sclk     - SPI clock, idle low
//          mosi     - serial data out
//          rx_byte  - received byte, complete when done is high
//          done     - high during the final clock of the byte
module spi_byte_xfer #(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic             running;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic             half_end;

  assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign mosi     = tx_sh[7];
  // Last low half of bit 7: the caller may move on at the next edge.
  assign done     = running && !sclk && half_end && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_byte <= '0;
      sclk    <= 1'b0;
    end else if (!running) begin
      tx_sh   <= tx_byte;
      div_cnt <= '0;
      bit_cnt <= '0;
      if (start) begin
        running <= 1'b1;
        sclk    <= 1'b1;
        rx_byte <= {rx_byte[6:0], miso};
      end
    end else if (half_end) begin
      div_cnt <= '0;
      if (sclk) begin
        sclk  <= 1'b0;
        tx_sh <= {tx_sh[6:0], 1'b0};
      end else if (bit_cnt == 3'd7) begin
        running <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        sclk    <= 1'b1;
        rx_byte <= {rx_byte[6:0], miso};
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmod_jstk_reader.sv
// rtl/pmod_jstk_reader.sv - periodic PmodJSTK 5-byte SPI frame reader
// Purpose: polls the joystick every POLL_PERIOD clocks while enable is high.
//          Each frame: ss_n low, SS_SETUP clocks, then five byte exchanges
//          separated by BYTE_GAP clocks; byte 0 carries the LED command.
//          Received bytes collect in a shadow register and are published to
//          jstk_data in one step when the frame finishes.
// Ports:   clk, reset (async, active-high)
//          enable     - permits new frames to start
//          led[1:0]   - LED bits, captured at frame start
//          miso       - serial data from joystick
//          ss_n       - slave select, active-low
//          sclk, mosi - SPI clock (idle low) and data to joystick
//          jstk_data  - last complete frame {XL, XH, YL, YH, buttons}
//          data_valid - one-clock pulse when jstk_data updates
//          busy       - high while ss_n is low
module pmod_jstk_reader
  import jstk_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int SS_SETUP    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_PERIOD = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  led,
  input  logic        miso,
  output logic        ss_n,
  output logic        sclk,
  output logic        mosi,
  output logic [39:0] jstk_data,
  output logic        data_valid,
  output logic        busy
);

  localparam int         CNT_MAX   = max3(SS_SETUP, BYTE_GAP, POLL_PERIOD);
  localparam int         CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [2:0] LAST_BYTE = 3'(JSTK_NBYTES - 1);

  jstk_state_t      state;
  jstk_state_t      state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       byte_idx;
  logic [7:0]       cmd_reg;
  logic [39:0]      shadow;
  logic [7:0]       tx_byte;
  logic [7:0]       rx_byte;
  logic             xfer_start;
  logic             xfer_done;
  logic             frame_active_next;

  // Only byte 0 carries the command; the rest are dummy reads.
  assign tx_byte = (byte_idx == 3'd0) ? cmd_reg : 8'h00;

  spi_byte_xfer #(
    .CLK_DIV(CLK_DIV)
  ) u_xfer (
    .clk     (clk),
    .reset   (reset),
    .start   (xfer_start),
    .tx_byte (tx_byte),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .rx_byte (rx_byte),
    .done    (xfer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is raised in the last SETUP/GAP clock so that sclk rises on the
  // same edge that enters XFER.
  always_comb begin
    state_next = state;
    xfer_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (cnt == CNT_W'(SS_SETUP - 1)) begin
          state_next = ST_XFER;
          xfer_start = 1'b1;
        end
      end
      ST_XFER: begin
        if (xfer_done) state_next = (byte_idx == LAST_BYTE) ? ST_FINISH : ST_GAP;
      end
      ST_GAP: begin
        if (cnt == CNT_W'(BYTE_GAP - 1)) begin
          state_next = ST_XFER;
          xfer_start = 1'b1;
        end
      end
      ST_FINISH: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(POLL_PERIOD - 1)) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign frame_active_next = (state_next == ST_SETUP) || (state_next == ST_XFER) ||
                             (state_next == ST_GAP);

  // Interval counter restarts from 0 on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if (state == ST_SETUP || state == ST_GAP || state == ST_WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_n       <= 1'b1;
      busy       <= 1'b0;
      cmd_reg    <= '0;
      byte_idx   <= '0;
      shadow     <= '0;
      jstk_data  <= '0;
      data_valid <= 1'b0;
    end else begin
      // Both follow the next state so they switch together on one edge.
      ss_n       <= !frame_active_next;
      busy       <= frame_active_next;
      data_valid <= 1'b0;

      if (state == ST_IDLE && enable) begin
        cmd_reg  <= JSTK_CMD | {6'b0, led};
        byte_idx <= '0;
        shadow   <= '0;
      end

      if (state == ST_XFER && xfer_done) begin
        case (byte_idx)
          3'd0:    shadow[JSTK_OFS_X_LO +: 8] <= rx_byte;
          3'd1:    shadow[JSTK_OFS_X_HI +: 8] <= rx_byte;
          3'd2:    shadow[JSTK_OFS_Y_LO +: 8] <= rx_byte;
          3'd3:    shadow[JSTK_OFS_Y_HI +: 8] <= rx_byte;
          default: shadow[JSTK_OFS_BTN  +: 8] <= rx_byte;
        endcase
        // Advance before GAP so tx_byte is settled ahead of the next start.
        if (byte_idx != LAST_BYTE) byte_idx <= byte_idx + 3'd1;
      end

      if (state == ST_FINISH) begin
        jstk_data  <= shadow;
        data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pmod_jstk_reader.sv
// tb/tb_pmod_jstk_reader.sv - self-checking bench for pmod_jstk_reader
module tb_pmod_jstk_reader;

  localparam int CLK_DIV     = 2;
  localparam int SS_SETUP    = 10;
  localparam int BYTE_GAP    = 6;
  localparam int POLL_PERIOD = 20;
  localparam int BYTE_CLKS   = 16 * CLK_DIV;
  localparam int FRAME_LOW   = SS_SETUP + 5 * BYTE_CLKS + 4 * BYTE_GAP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  led = 2'b00;
  logic        miso = 1'b0;
  logic        ss_n;
  logic        sclk;
  logic        mosi;
  logic [39:0] jstk_data;
  logic        data_valid;
  logic        busy;

  pmod_jstk_reader #(
    .CLK_DIV(CLK_DIV),
    .SS_SETUP(SS_SETUP),
    .BYTE_GAP(BYTE_GAP),
    .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .led(led),
    .miso(miso),
    .ss_n(ss_n),
    .sclk(sclk),
    .mosi(mosi),
    .jstk_data(jstk_data),
    .data_valid(data_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Joystick model and reference state
  int          cyc = 0;
  logic        prev_ss_n = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [1:0]  led_prev = 2'b00;
  bit          in_frame = 0;
  int          fall_cyc = 0;
  int          rise_cnt = 0;
  int          exp_off;
  logic [39:0] resp_sh;
  logic [39:0] cur_resp;
  logic [39:0] mosi_cap;
  logic [7:0]  exp_cmd;
  logic [39:0] exp_data = '0;
  logic [39:0] pending = '0;
  bit          pending_valid = 0;
  int          pend_age = 0;
  int          n_frames = 0;
  int          dv_count = 0;
  int          last_dur = 0;
  int          last_first_rise = 0;
  int          last_rises = 0;
  logic [7:0]  last_cmd = '0;
  logic [39:0] resp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("reset_state", 64'({ss_n, sclk, mosi, data_valid, busy, jstk_data}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 40'h0}));
      in_frame      = 0;
      pending_valid = 0;
      exp_data      = '0;
      miso          = 1'b0;
    end else begin
      if (prev_ss_n && !ss_n) begin
        n_frames++;
        in_frame = 1;
        fall_cyc = cyc;
        rise_cnt = 0;
        mosi_cap = '0;
        cur_resp = (resp_q.size() > 0) ? resp_q.pop_front() : {8'($urandom), $urandom};
        resp_sh  = cur_resp;
        exp_cmd  = 8'h80 | {6'b0, led_prev};
        miso     = resp_sh[39];
      end
      if (in_frame && prev_sclk && !sclk) begin
        resp_sh = resp_sh << 1;
        miso    = resp_sh[39];
      end
      if (in_frame && !prev_sclk && sclk) begin
        if (rise_cnt < 40) begin
          exp_off = SS_SETUP + (rise_cnt / 8) * (BYTE_CLKS + BYTE_GAP) + (rise_cnt % 8) * 2 * CLK_DIV;
          check("sclk_rise_time", 64'(cyc - fall_cyc), 64'(exp_off));
        end else begin
          check("sclk_rise_count", 64'(rise_cnt + 1), 64'(40));
        end
        if (rise_cnt == 0) last_first_rise = cyc - fall_cyc;
        mosi_cap = {mosi_cap[38:0], mosi};
        rise_cnt++;
      end
      if (in_frame && !prev_ss_n && ss_n) begin
        in_frame   = 0;
        last_dur   = cyc - fall_cyc;
        last_rises = rise_cnt;
        last_cmd   = mosi_cap[39:32];
        check("frame_low_clocks", 64'(last_dur), 64'(FRAME_LOW));
        check("frame_sclk_rises", 64'(rise_cnt), 64'(40));
        check("frame_mosi", 64'(mosi_cap), 64'({exp_cmd, 32'h0}));
        pending       = cur_resp;
        pending_valid = 1;
        pend_age      = 0;
      end
      check("busy_vs_ss_n", 64'(busy), 64'(!ss_n));
      if (ss_n) check("sclk_idle", 64'(sclk), 64'(0));
      if (data_valid) begin
        check("dv_expected", 64'(pending_valid), 64'(1));
        check("dv_latency", 64'(pend_age <= 1), 64'(1));
        check("jstk_data_update", 64'(jstk_data), 64'(pending));
        if (pending_valid) exp_data = pending;
        pending_valid = 0;
        dv_count++;
      end else begin
        check("jstk_data_hold", 64'(jstk_data), 64'(exp_data));
        if (pending_valid) begin
          pend_age++;
          if (pend_age > 2) begin
            check("dv_after_frame", 64'(pend_age), 64'(1));
            pending_valid = 0;
          end
        end
      end
    end
    prev_ss_n = ss_n;
    prev_sclk = sclk;
    led_prev  = led;
  end

  task automatic wait_dv(input int target, input int limit);
    for (int i = 0; i < limit && dv_count < target; i++) @(posedge clk);
    #1;
    check("wait_dv", 64'(dv_count >= target), 64'(1));
  endtask

  task automatic wait_byte(input int lo, input int hi, input int limit);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = in_frame && rise_cnt >= lo && rise_cnt < hi;
    end
    check("wait_byte", 64'(hit), 64'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int frames0;
  int dvs0;

  initial begin
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("no_frame_when_disabled", 64'(n_frames), 64'(0));

    // First frame: fixed response and LED pattern
    resp_q.push_back(40'h123456789A);
    led = 2'b01;
    enable = 1'b1;
    wait_dv(1, 400);
    check("frame1_data", 64'(jstk_data), 64'(40'h123456789A));
    check("frame1_cmd", 64'(last_cmd), 64'(8'h81));
    check("frame1_low", 64'(last_dur), 64'(194));
    check("frame1_setup", 64'(last_first_rise), 64'(10));

    // X = 700 across the two X bytes
    resp_q.push_back({8'hBC, 8'h02, 8'($urandom), 8'($urandom), 8'($urandom)});
    led = 2'b10;
    wait_dv(2, 400);
    check("x_700", 64'({jstk_data[25:24], jstk_data[39:32]}), 64'(700));

    // Random LED changes over several back-to-back frames
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) led = 2'($urandom);
    end
    check("random_frames_seen", 64'(n_frames >= 8), 64'(1));

    // enable dropped during byte 2
    wait_byte(16, 24, 600);
    enable = 1'b0;
    frames0 = n_frames;
    dvs0 = dv_count;
    repeat (FRAME_LOW + POLL_PERIOD + 60) @(posedge clk);
    #1;
    check("drop_no_new_frame", 64'(n_frames), 64'(frames0));
    check("drop_one_dv", 64'(dv_count), 64'(dvs0 + 1));
    check("drop_parked", 64'(ss_n), 64'(1));

    // reset during byte 3
    enable = 1'b1;
    wait_byte(24, 32, 600);
    dvs0 = dv_count;
    #2 reset = 1'b1;
    #1;
    check("reset_ss_n_async", 64'(ss_n), 64'(1));
    check("reset_jstk_clear", 64'(jstk_data), 64'(0));
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    check("reset_no_dv", 64'(dv_count), 64'(dvs0));
    @(posedge clk);
    #1;
    check("restart_first_clock", 64'(ss_n), 64'(0));
    wait_dv(dvs0 + 1, 400);
    check("post_reset_rises", 64'(last_rises), 64'(40));
    check("post_reset_low", 64'(last_dur), 64'(FRAME_LOW));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
